mem_io_ctrl: RTL and testbench

// - Memory-side bus controller directly downstream of the cpu byte bus (mem_a/mem_dout/mem_wr/mem_din).
// - Decodes each access to 128KB RAM or memory-mapped I/O. Returns read data with a fixed 1-cycle latency.
// - Buffers UART TX bytes in a FIFO, drives io_buffer_full back to the cpu, and keeps the cycle counter.
// - Raises program_stop when the cpu writes 0x30004.

---
 rtl/mem_io_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_io_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// Memory-side bus controller: RAM/IO decode, 1-cycle read return, UART TX FIFO and cycle counter.
// Optional MEM_IO_DROP_CNT_EN adds a saturating dropped-push counter readable at 0x30008.
module mem_io_ctrl #(
    parameter int TX_FIFO_WIDTH = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_pop,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    output logic        program_stop
);

    localparam int DEPTH = 1 << TX_FIFO_WIDTH;
    localparam logic [TX_FIFO_WIDTH:0] DEPTH_C  = (TX_FIFO_WIDTH+1)'(DEPTH);
    localparam logic [TX_FIFO_WIDTH:0] MARGIN_C = (TX_FIFO_WIDTH+1)'(FULL_MARGIN);

    logic                   is_io, io_rd, io_wr;
    logic [3:0]             off;
    logic [31:0]            cyc_cnt_q, cyc_cnt_d;
    logic [31:0]            snap_q, snap_d;
    logic                   src_q, src_d;
    logic [7:0]             io_rdata_q, io_rdata_d;
    logic                   stop_q, stop_d;
    logic [TX_FIFO_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [7:0]             mem_q [DEPTH];
    logic                   push_req, push_ok, pop, full;
    logic [7:0]             push_data;
    logic                   unused_a;
`ifdef MEM_IO_DROP_CNT_EN
    logic [7:0]             drop_cnt_q, drop_cnt_d;
`endif

    assign unused_a = ^cpu_a[31:18];
    assign is_io    = (cpu_a[17:16] == 2'b11);
    assign off      = cpu_a[3:0];
    assign io_rd    = is_io & ~cpu_wr;
    assign io_wr    = is_io & cpu_wr;

    assign ram_a   = cpu_a[16:0];
    assign ram_din = cpu_dout;
    assign ram_we  = cpu_wr & ~is_io & ~rst_in;

    assign count          = wr_ptr_q - rd_ptr_q;
    assign full           = (count == DEPTH_C);
    // Outputs are forced to their idle values while reset is held, even on the first reset cycle.
    assign uart_tx_valid  = (count != '0) & ~rst_in;
    assign uart_tx_data   = mem_q[rd_ptr_q[TX_FIFO_WIDTH-1:0]];
    assign io_buffer_full = ((DEPTH_C - count) <= MARGIN_C) & ~rst_in;
    assign pop            = uart_tx_valid & uart_tx_ready;
    assign push_ok        = push_req & (~full | pop) & ~rst_in;
    assign cpu_din        = (src_q & ~rst_in) ? io_rdata_q : ram_dout;
    assign program_stop   = stop_q;

    always_comb begin
        cyc_cnt_d   = cyc_cnt_q + 32'd1;
        snap_d      = snap_q;
        src_d       = io_rd;
        io_rdata_d  = 8'h00;
        stop_d      = stop_q;
        push_req    = 1'b0;
        push_data   = cpu_dout;
        uart_rx_pop = 1'b0;
        if (io_rd) begin
            case (off)
                4'h0: begin
                    io_rdata_d  = uart_rx_valid ? uart_rx_data : 8'h00;
                    uart_rx_pop = uart_rx_valid & ~rst_in;
                end
                // Byte 0 comes live while the snapshot is taken, so bytes 1..3 match it.
                4'h4: begin
                    io_rdata_d = cyc_cnt_q[7:0];
                    snap_d     = cyc_cnt_q;
                end
                4'h5: io_rdata_d = snap_q[15:8];
                4'h6: io_rdata_d = snap_q[23:16];
                4'h7: io_rdata_d = snap_q[31:24];
`ifdef MEM_IO_DROP_CNT_EN
                4'h8: io_rdata_d = drop_cnt_q;
`endif
                default: io_rdata_d = 8'h00;
            endcase
        end
        if (io_wr) begin
            case (off)
                4'h0: push_req = (cpu_dout != 8'h00);
                4'h4: begin
                    stop_d    = 1'b1;
                    push_req  = 1'b1;
                    push_data = 8'h00;
                end
                default: push_req = 1'b0;
            endcase
        end
        wr_ptr_d = wr_ptr_q + (TX_FIFO_WIDTH+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (TX_FIFO_WIDTH+1)'(pop);
`ifdef MEM_IO_DROP_CNT_EN
        drop_cnt_d = drop_cnt_q;
        if (push_req && full && !pop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc_cnt_q  <= '0;
            snap_q     <= '0;
            src_q      <= 1'b0;
            io_rdata_q <= 8'h00;
            stop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef MEM_IO_DROP_CNT_EN
            drop_cnt_q <= 8'h00;
`endif
        end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            snap_q     <= snap_d;
            src_q      <= src_d;
            io_rdata_q <= io_rdata_d;
            stop_q     <= stop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef MEM_IO_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[TX_FIFO_WIDTH-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: directed and random bus accesses checked against a queue/array model.
module tb_mem_io_ctrl;

    localparam logic [31:0] IO_TX   = 32'h0003_0000;
    localparam logic [31:0] IO_CYC  = 32'h0003_0004;
    localparam logic [31:0] IO_DROP = 32'h0003_0008;
    localparam logic [31:0] IO_IDLE = 32'h0003_000F;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_pop;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic        program_stop;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  ram_ref [int];
    logic [31:0] cyc_m  = 32'd0;
    logic [31:0] snap_m = 32'd0;
    logic        stop_m = 1'b0;
    logic [7:0]  drop_m = 8'd0;
    logic        m_io, m_pop, m_push;
    logic [7:0]  m_byte;
    logic [7:0]  last_din;

    always #5 clk = ~clk;

    mem_io_ctrl dut (
        .clk_in(clk), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_pop(uart_rx_pop), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready), .program_stop(program_stop)
    );

    // external synchronous RAM
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    always @(posedge clk) begin
        if (rst_in) begin
            tx_q.delete();
            cyc_m  <= 32'd0;
            stop_m <= 1'b0;
            drop_m <= 8'd0;
        end else begin
            m_io   = (cpu_a[17:16] == 2'b11);
            m_pop  = (tx_q.size() != 0) && uart_tx_ready;
            m_push = cpu_wr && m_io && ((cpu_a[3:0] == 4'h0 && cpu_dout != 8'h00) || cpu_a[3:0] == 4'h4);
            m_byte = (cpu_a[3:0] == 4'h4) ? 8'h00 : cpu_dout;
            cyc_m <= cyc_m + 32'd1;
            if (cpu_wr && m_io && cpu_a[3:0] == 4'h4) stop_m <= 1'b1;
            if (m_pop) void'(tx_q.pop_front());
            if (m_push) begin
                if (tx_q.size() < 8) tx_q.push_back(m_byte);
                else if (drop_m != 8'hFF) drop_m <= drop_m + 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tx();
        check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, tx_q.size() != 0});
        if (tx_q.size() != 0) check("tx_data", {24'd0, uart_tx_data}, {24'd0, tx_q[0]});
        check("buf_full", {31'd0, io_buffer_full}, {31'd0, (8 - tx_q.size()) <= 2});
        check("prog_stop", {31'd0, program_stop}, {31'd0, stop_m});
    endtask

    // one bus access: drive after the edge, check combinational outputs mid-cycle,
    // check returned data and TX state just after the next edge
    task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d, input logic rdy);
        logic       io, chk;
        logic [3:0] off;
        logic [7:0] exp;
        cpu_a = a; cpu_wr = wr; cpu_dout = d; uart_tx_ready = rdy;
        uart_rx_valid = 1'($urandom_range(0, 1));
        uart_rx_data  = 8'($urandom_range(1, 255));
        io = (a[17:16] == 2'b11); off = a[3:0]; chk = 1'b0; exp = 8'h00;
        @(negedge clk);
        check("ram_we", {31'd0, ram_we}, {31'd0, wr & ~io});
        check("rx_pop", {31'd0, uart_rx_pop}, {31'd0, !wr && io && off == 4'h0 && uart_rx_valid});
        if (!wr) begin
            if (!io) begin
                if (ram_ref.exists(int'(a[16:0]))) begin
                    chk = 1'b1; exp = ram_ref[int'(a[16:0])];
                end
            end else begin
                chk = 1'b1;
                case (off)
                    4'h0: exp = uart_rx_valid ? uart_rx_data : 8'h00;
                    4'h4: begin exp = cyc_m[7:0]; snap_m = cyc_m; end
                    4'h5: exp = snap_m[15:8];
                    4'h6: exp = snap_m[23:16];
                    4'h7: exp = snap_m[31:24];
`ifdef MEM_IO_DROP_CNT_EN
                    4'h8: exp = drop_m;
`endif
                    default: exp = 8'h00;
                endcase
            end
        end else if (!io) begin
            ram_ref[int'(a[16:0])] = d;
        end
        @(posedge clk); #1;
        last_din = cpu_din;
        if (chk) check("cpu_din", {24'd0, cpu_din}, {24'd0, exp});
        check_tx();
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                cpu_a = 32'h10; cpu_wr = 1'b1; cpu_dout = 8'hEE;
            end else begin
                cpu_a = IO_TX; cpu_wr = 1'b0; uart_rx_valid = 1'b1;
            end
            @(negedge clk);
            check("rst_ram_we", {31'd0, ram_we}, 32'd0);
            check("rst_rx_pop", {31'd0, uart_rx_pop}, 32'd0);
            check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
            check("rst_buf_full", {31'd0, io_buffer_full}, 32'd0);
            @(posedge clk); #1;
        end
        rst_in = 1'b0; snap_m = 32'd0;
        cpu_a = IO_IDLE; cpu_wr = 1'b0;
        check_tx();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int r;
        logic [7:0] b0, b1, b2, b3;
        rst_in = 1'b1; cpu_a = IO_IDLE; cpu_wr = 1'b0; cpu_dout = 8'h00;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        @(posedge clk); #1;
        do_reset(4);

        // RAM write then read, 1-cycle return
        access(32'h10, 1'b1, 8'hA5, 1'b0);
        access(32'h10, 1'b0, 8'h00, 1'b0);
        check("ram_rd_a5", {24'd0, last_din}, 32'h0000_00A5);

        // zero byte is not pushed
        access(IO_TX, 1'b1, 8'h41, 1'b0);
        access(IO_TX, 1'b1, 8'h00, 1'b0);
        access(IO_TX, 1'b1, 8'h42, 1'b0);
        check("tx_head_41", {24'd0, uart_tx_data}, 32'h41);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);
        check("tx_head_42", {24'd0, uart_tx_data}, 32'h42);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);
        check("tx_empty", {31'd0, uart_tx_valid}, 32'd0);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);

        // fill to near-full, overflow, simultaneous push/pop while full
        for (int i = 0; i < 6; i++) access(IO_TX, 1'b1, 8'(8'h10 + i), 1'b0);
        check("full_at_6", {31'd0, io_buffer_full}, 32'd1);
        for (int i = 0; i < 3; i++) access(IO_TX, 1'b1, 8'(8'h20 + i), 1'b0);
        access(IO_DROP, 1'b0, 8'h00, 1'b0);
        access(IO_TX, 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 10; i++) access(IO_IDLE, 1'b0, 8'h00, 1'b1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: access(32'($urandom_range(0, 63)), 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                1: access(32'($urandom_range(0, 63)), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                2: access(IO_TX, 1'b1, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255)), 1'($urandom_range(0, 3) == 0));
                3: access(IO_TX, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                4: access(IO_CYC + 32'($urandom_range(0, 4)), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
                default: access(IO_IDLE, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
            endcase
        end
        for (int i = 0; i < 12; i++) access(IO_IDLE, 1'b0, 8'h00, 1'b1);

        // coherent 4-byte cycle counter read across a byte carry
        do_reset(3);
        guard = 0;
        while (cyc_m != 32'h1FF && guard < 2000) begin
            access(IO_IDLE, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        check("cyc_reached", {31'd0, guard < 2000}, 32'd1);
        access(IO_CYC, 1'b0, 8'h00, 1'b0);          b0 = last_din;
        access(IO_CYC + 32'd1, 1'b0, 8'h00, 1'b0);  b1 = last_din;
        access(IO_CYC + 32'd2, 1'b0, 8'h00, 1'b0);  b2 = last_din;
        access(IO_CYC + 32'd3, 1'b0, 8'h00, 1'b0);  b3 = last_din;
        check("cyc_word", {b3, b2, b1, b0}, 32'h0000_01FF);

        // program stop, terminator, sticky, then reset mid-drain
        access(IO_TX, 1'b1, 8'h55, 1'b0);
        access(IO_CYC, 1'b1, 8'h99, 1'b0);
        check("stop_set", {31'd0, program_stop}, 32'd1);
        access(IO_TX, 1'b1, 8'h66, 1'b0);
        check("stop_sticky", {31'd0, program_stop}, 32'd1);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);
        check("terminator", {24'd0, uart_tx_data}, 32'h00);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);
        do_reset(2);
        check("rst_stop", {31'd0, program_stop}, 32'd0);
        check("rst_empty", {31'd0, uart_tx_valid}, 32'd0);
        access(IO_IDLE, 1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
